// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and load/store
// requests onto a single 8-bit RAM port with one cycle of read latency.
module mem_ctrl #(
  parameter logic [1:0] IO_PREFIX = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_en_o,
  output logic [31:0] inst_data_o,
  input  logic        lsb_req_i,
  input  logic        lsb_we_i,
  input  logic [31:0] lsb_addr_i,
  input  logic [1:0]  lsb_size_i,
  input  logic [31:0] lsb_wdata_i,
  output logic        lsb_done_o,
  output logic [31:0] lsb_rdata_o,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        inst_en_q, inst_en_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic [7:0]  din_hold_q;
  logic        hold_vld_q;

  logic [2:0]  step;
  logic [2:0]  nbytes;
  logic [1:0]  cap_idx;
  logic [1:0]  last_idx;
  logic [7:0]  din_eff;
  logic [31:0] word_done;
  logic        pulse_busy;
  logic        io_blocked;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  // step is the edge index relative to acceptance; byte k is captured two edges after its address
  assign step       = cnt_q + 3'd1;
  assign nbytes     = size_to_bytes(size_q);
  assign cap_idx    = step[1:0] - 2'd2;
  assign last_idx   = nbytes[1:0] - 2'd1;
  assign din_eff    = hold_vld_q ? din_hold_q : mem_din;
  assign word_done  = put_byte(buf_q, last_idx, din_eff);
  assign pulse_busy = inst_en_q | lsb_done_q;
  assign io_blocked = (lsb_addr_i[17:16] == IO_PREFIX) && io_buffer_full;

  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = mem_wr_q & rdy_in;
  assign inst_en_o   = inst_en_q;
  assign inst_data_o = inst_data_q;
  assign lsb_done_o  = lsb_done_q;
  assign lsb_rdata_o = lsb_rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    inst_en_d   = 1'b0;
    lsb_done_d  = 1'b0;
    inst_data_d = inst_data_q;
    lsb_rdata_d = lsb_rdata_q;

    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          mem_wr_d = 1'b0;
          // the requester still holds its request while seeing its done pulse
          if (!pulse_busy) begin
            if (lsb_req_i) begin
              if (lsb_we_i) begin
                if (!io_blocked) begin
                  state_d    = STORE;
                  cnt_d      = 3'd0;
                  addr_d     = lsb_addr_i;
                  size_d     = lsb_size_i;
                  wdata_d    = lsb_wdata_i;
                  mem_a_d    = lsb_addr_i;
                  mem_dout_d = lsb_wdata_i[7:0];
                  mem_wr_d   = 1'b1;
                end
              end else if (!clear) begin
                state_d = LOAD;
                cnt_d   = 3'd0;
                addr_d  = lsb_addr_i;
                size_d  = lsb_size_i;
                buf_d   = 32'd0;
                mem_a_d = lsb_addr_i;
              end
            end else if (inst_req_i && !clear) begin
              state_d = IFETCH;
              cnt_d   = 3'd0;
              addr_d  = inst_addr_i;
              size_d  = 2'd2;
              buf_d   = 32'd0;
              mem_a_d = inst_addr_i;
            end
          end
        end

        IFETCH, LOAD: begin
          if (clear) begin
            state_d  = IDLE;
            cnt_d    = 3'd0;
            mem_wr_d = 1'b0;
          end else begin
            cnt_d = step;
            if (step < nbytes)
              mem_a_d = addr_q + {29'd0, step};
            if (step >= 3'd2 && step <= nbytes)
              buf_d = put_byte(buf_q, cap_idx, din_eff);
            if (step == nbytes + 3'd1) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              if (state_q == IFETCH) begin
                inst_data_d = word_done;
                inst_en_d   = 1'b1;
              end else begin
                lsb_rdata_d = word_done;
                lsb_done_d  = 1'b1;
              end
            end
          end
        end

        STORE: begin
          if (step < nbytes) begin
            cnt_d      = step;
            mem_a_d    = addr_q + {29'd0, step};
            mem_dout_d = get_byte(wdata_q, step[1:0]);
            mem_wr_d   = 1'b1;
          end else begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
          end
        end

        default: begin
          state_d  = IDLE;
          cnt_d    = 3'd0;
          mem_wr_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      inst_en_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      inst_data_q <= 32'd0;
      lsb_rdata_q <= 32'd0;
      hold_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      inst_en_q   <= inst_en_d;
      lsb_done_q  <= lsb_done_d;
      inst_data_q <= inst_data_d;
      lsb_rdata_q <= lsb_rdata_d;
      hold_vld_q  <= !rdy_in;
    end
  end

  // RAM keeps reading the frozen address, so the byte in flight when the stall began is parked here
  always_ff @(posedge clk_in) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
    buf_q   <= buf_d;
    if (!rdy_in && !hold_vld_q)
      din_hold_q <= mem_din;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic        inst_en_o;
  logic [31:0] inst_data_o;
  logic        lsb_req_i, lsb_we_i;
  logic [31:0] lsb_addr_i;
  logic [1:0]  lsb_size_i;
  logic [31:0] lsb_wdata_i;
  logic        lsb_done_o;
  logic [31:0] lsb_rdata_o;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic [7:0]  ram [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  int          wr_count = 0;

  int n_asrt = 0;
  int n_fail = 0;
  int wr_before;

  mem_ctrl #(.IO_PREFIX(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
    .inst_en_o(inst_en_o), .inst_data_o(inst_data_o),
    .lsb_req_i(lsb_req_i), .lsb_we_i(lsb_we_i), .lsb_addr_i(lsb_addr_i),
    .lsb_size_i(lsb_size_i), .lsb_wdata_i(lsb_wdata_i),
    .lsb_done_o(lsb_done_o), .lsb_rdata_o(lsb_rdata_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wr_count <= wr_count + 1;
    end
    if (pl_we) ram[pl_addr] <= pl_data;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic lsb_set(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd);
    lsb_req_i = 1'b1; lsb_we_i = we; lsb_addr_i = a; lsb_size_i = sz; lsb_wdata_i = wd;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    inst_req_i = 1'b0; inst_addr_i = 32'd0;
    lsb_req_i = 1'b0; lsb_we_i = 1'b0; lsb_addr_i = 32'd0; lsb_size_i = 2'd0; lsb_wdata_i = 32'd0;
    io_buffer_full = 1'b0;
    pl_we = 1'b0; pl_addr = 16'd0; pl_data = 8'd0;

    // reset state
    tick(); tick();
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_inst_en", {31'd0, inst_en_o}, 32'd0);
    chk("rst_lsb_done", {31'd0, lsb_done_o}, 32'd0);
    chk("rst_inst_data", inst_data_o, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata_o, 32'd0);
    rst_in = 1'b0;

    poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
    poke(16'h0200, 8'h78); poke(16'h0201, 8'h56); poke(16'h0202, 8'h34); poke(16'h0203, 8'h12);
    poke(16'h0300, 8'hEF); poke(16'h0301, 8'hBE); poke(16'h0302, 8'hAD); poke(16'h0303, 8'hDE);
    poke(16'h0400, 8'h44); poke(16'h0401, 8'h33); poke(16'h0402, 8'h22); poke(16'h0403, 8'h11);
    poke(16'hFFFF, 8'h77);

    // fetch word at 0x100
    inst_req_i = 1'b1; inst_addr_i = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fetch_addr", mem_a, 32'h100 + k);
      chk("fetch_wr", {31'd0, mem_wr}, 32'd0);
    end
    tick();
    chk("fetch_early", {31'd0, inst_en_o}, 32'd0);
    tick();
    chk("fetch_en", {31'd0, inst_en_o}, 32'd1);
    chk("fetch_data", inst_data_o, 32'h00000513);
    inst_req_i = 1'b0;
    tick();
    chk("fetch_pulse_end", {31'd0, inst_en_o}, 32'd0);
    chk("fetch_hold", inst_data_o, 32'h00000513);

    // collision: load beats fetch
    inst_req_i = 1'b1; inst_addr_i = 32'h300;
    lsb_set(1'b0, 32'h200, 2'd2, 32'd0);
    tick();
    chk("coll_load_first", mem_a, 32'h200);
    repeat (4) tick();
    chk("coll_load_early", {31'd0, lsb_done_o}, 32'd0);
    tick();
    chk("coll_done", {31'd0, lsb_done_o}, 32'd1);
    chk("coll_rdata", lsb_rdata_o, 32'h12345678);
    chk("coll_no_inst", {31'd0, inst_en_o}, 32'd0);
    lsb_req_i = 1'b0;
    tick();
    chk("coll_done_end", {31'd0, lsb_done_o}, 32'd0);
    chk("coll_fetch_waits", mem_a, 32'h203);
    tick();
    chk("coll_fetch_start", mem_a, 32'h300);
    repeat (4) tick();
    chk("coll_fetch_early", {31'd0, inst_en_o}, 32'd0);
    tick();
    chk("coll_fetch_en", {31'd0, inst_en_o}, 32'd1);
    chk("coll_fetch_data", inst_data_o, 32'hDEADBEEF);
    inst_req_i = 1'b0;
    tick();

    // store half 0xABCD to 0x1001, then load it back
    lsb_set(1'b1, 32'h1001, 2'd1, 32'h0000ABCD);
    tick();
    chk("st_wr0", {31'd0, mem_wr}, 32'd1);
    chk("st_a0", mem_a, 32'h1001);
    chk("st_d0", {24'd0, mem_dout}, 32'hCD);
    tick();
    chk("st_wr1", {31'd0, mem_wr}, 32'd1);
    chk("st_a1", mem_a, 32'h1002);
    chk("st_d1", {24'd0, mem_dout}, 32'hAB);
    tick();
    chk("st_wr_off", {31'd0, mem_wr}, 32'd0);
    chk("st_done", {31'd0, lsb_done_o}, 32'd1);
    lsb_req_i = 1'b0;
    tick();
    chk("st_done_end", {31'd0, lsb_done_o}, 32'd0);
    chk("st_ram", {16'd0, ram[16'h1002], ram[16'h1001]}, 32'h0000ABCD);
    lsb_set(1'b0, 32'h1001, 2'd1, 32'd0);
    repeat (3) tick();
    chk("ldh_early", {31'd0, lsb_done_o}, 32'd0);
    tick();
    chk("ldh_done", {31'd0, lsb_done_o}, 32'd1);
    chk("ldh_rdata", lsb_rdata_o, 32'h0000ABCD);
    lsb_req_i = 1'b0;
    tick();

    // fetch aborted by clear at the third byte, then a clean fetch
    inst_req_i = 1'b1; inst_addr_i = 32'h300;
    tick(); tick(); tick();
    chk("clr_third", mem_a, 32'h302);
    clear = 1'b1;
    tick();
    chk("clr_idle", mem_a, 32'h302);
    chk("clr_no_en", {31'd0, inst_en_o}, 32'd0);
    chk("clr_no_wr", {31'd0, mem_wr}, 32'd0);
    clear = 1'b0; inst_addr_i = 32'h100;
    tick();
    chk("clr_refetch", mem_a, 32'h100);
    repeat (4) tick();
    chk("clr_refetch_early", {31'd0, inst_en_o}, 32'd0);
    tick();
    chk("clr_refetch_en", {31'd0, inst_en_o}, 32'd1);
    chk("clr_refetch_data", inst_data_o, 32'h00000513);
    inst_req_i = 1'b0;
    tick();

    // I/O store held off while the UART buffer is full
    wr_before = wr_count;
    io_buffer_full = 1'b1;
    lsb_set(1'b1, 32'h30000, 2'd0, 32'h0000005A);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("io_blocked_wr", {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    chk("io_wr", {31'd0, mem_wr}, 32'd1);
    chk("io_addr", mem_a, 32'h30000);
    chk("io_data", {24'd0, mem_dout}, 32'h5A);
    tick();
    chk("io_done", {31'd0, lsb_done_o}, 32'd1);
    chk("io_wr_off", {31'd0, mem_wr}, 32'd0);
    lsb_req_i = 1'b0;
    tick();
    chk("io_one_write", wr_count - wr_before, 32'd1);

    // half load across the 32-bit address wrap
    lsb_set(1'b0, 32'hFFFFFFFF, 2'd1, 32'd0);
    tick();
    chk("wrap_a0", mem_a, 32'hFFFFFFFF);
    tick();
    chk("wrap_a1", mem_a, 32'h00000000);
    tick(); tick();
    chk("wrap_done", {31'd0, lsb_done_o}, 32'd1);
    chk("wrap_rdata", lsb_rdata_o, 32'h00005A77);
    lsb_req_i = 1'b0;
    tick();

    // three-cycle stall in the middle of a word load
    lsb_set(1'b0, 32'h400, 2'd2, 32'd0);
    tick(); tick();
    chk("frz_pre", mem_a, 32'h401);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_addr", mem_a, 32'h401);
      chk("frz_no_done", {31'd0, lsb_done_o}, 32'd0);
    end
    rdy_in = 1'b1;
    repeat (3) tick();
    chk("frz_early", {31'd0, lsb_done_o}, 32'd0);
    tick();
    chk("frz_done", {31'd0, lsb_done_o}, 32'd1);
    chk("frz_rdata", lsb_rdata_o, 32'h11223344);
    lsb_req_i = 1'b0;
    tick();

    // stall gating of mem_wr, then reset in the middle of a store
    lsb_set(1'b1, 32'h2000, 2'd2, 32'h11223344);
    tick();
    chk("mrst_wr0", {31'd0, mem_wr}, 32'd1);
    rdy_in = 1'b0;
    #1;
    chk("mrst_wr_gated", {31'd0, mem_wr}, 32'd0);
    rdy_in = 1'b1;
    tick();
    chk("mrst_a1", mem_a, 32'h2001);
    rst_in = 1'b1;
    tick();
    chk("mrst_mem_a", mem_a, 32'd0);
    chk("mrst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("mrst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("mrst_done", {31'd0, lsb_done_o}, 32'd0);
    chk("mrst_rdata", lsb_rdata_o, 32'd0);
    chk("mrst_inst_data", inst_data_o, 32'd0);
    rst_in = 1'b0; lsb_req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_no_done", {31'd0, lsb_done_o}, 32'd0);
      chk("mrst_no_wr", {31'd0, mem_wr}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
